// File: rtl/operand_dispatch_demux_if.sv
// rtl/operand_dispatch_demux_if.sv - operand dispatch bus: one input beat, NUM_CH output channels
interface operand_dispatch_demux_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         in_sel;
  logic [DATA_W-1:0]        in_rs1;
  logic [DATA_W-1:0]        in_rs2;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_rs1;
  logic [NUM_CH*DATA_W-1:0] out_rs2;
  logic                     sel_err;
  logic [NUM_CH*CNT_W-1:0]  issue_cnt;

  modport master (
    output in_valid, in_sel, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, sel_err, issue_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, sel_err, issue_cnt
  );
endinterface

// File: rtl/operand_dispatch_demux.sv
// rtl/operand_dispatch_demux.sv - registered 1-to-NUM_CH operand demux with per-channel valid/ready
module operand_dispatch_demux #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  operand_dispatch_demux_if.slave       bus
);

  logic [NUM_CH-1:0]        valid_q;
  logic [NUM_CH*DATA_W-1:0] rs1_q;
  logic [NUM_CH*DATA_W-1:0] rs2_q;
  logic [NUM_CH*CNT_W-1:0]  cnt_q;
  logic                     sel_err_q;

  logic [NUM_CH-1:0]        ch_free;
  logic [NUM_CH-1:0]        load;
  logic                     sel_ok;
  logic                     sel_free;
  logic                     in_ready_c;
  logic                     accept;

  // A channel can take a beat when empty or when its entry pops this cycle.
  always_comb begin
    ch_free  = ~valid_q | bus.out_ready;
    sel_ok   = int'(bus.in_sel) < NUM_CH;
    sel_free = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(bus.in_sel) == c) sel_free = ch_free[c];
    end
    if (flush)        in_ready_c = 1'b0;
    else if (!sel_ok) in_ready_c = 1'b1;
    else              in_ready_c = sel_free;
    accept = bus.in_valid && in_ready_c;
    load   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      load[c] = accept && sel_ok && (int'(bus.in_sel) == c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      // Out-of-range beats are consumed and dropped; flag them for one cycle.
      sel_err_q <= accept && !sel_ok;
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          valid_q[c] <= 1'b0;
        end else if (load[c]) begin
          valid_q[c]                  <= 1'b1;
          rs1_q[c*DATA_W +: DATA_W]   <= bus.in_rs1;
          rs2_q[c*DATA_W +: DATA_W]   <= bus.in_rs2;
          cnt_q[c*CNT_W +: CNT_W]     <= cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
        end else if (bus.out_ready[c]) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_rs1   = rs1_q;
  assign bus.out_rs2   = rs2_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_operand_dispatch_demux.sv
// tb/tb_operand_dispatch_demux.sv - directed self-checking bench for operand_dispatch_demux
module tb_operand_dispatch_demux;

  logic clk;
  logic rst_n;
  logic flush4;
  logic flush3;
  int   n_tests;
  int   n_fail;

  operand_dispatch_demux_if #(.DATA_W(16), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) if4 ();
  operand_dispatch_demux_if #(.DATA_W(16), .NUM_CH(3), .SEL_W(2), .CNT_W(8)) if3 ();

  operand_dispatch_demux #(.DATA_W(16), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(if4)
  );

  operand_dispatch_demux #(.DATA_W(16), .NUM_CH(3), .SEL_W(2), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rs1_4(input int c);
    return if4.out_rs1[c*16 +: 16];
  endfunction

  function automatic logic [15:0] rs2_4(input int c);
    return if4.out_rs2[c*16 +: 16];
  endfunction

  function automatic logic [7:0] cnt_4(input int c);
    return if4.issue_cnt[c*8 +: 8];
  endfunction

  task automatic beat4(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
    if4.in_valid = 1'b1;
    if4.in_sel   = sel;
    if4.in_rs1   = a;
    if4.in_rs2   = b;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid !== 4'b0000 || if4.out_rs1 !== 64'd0 || if4.out_rs2 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b rs1=%h rs2=%h, expected all 0", if4.out_valid, if4.out_rs1, if4.out_rs2);
    end
    n_tests++;
    if (if4.issue_cnt !== 32'd0 || if4.sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt: issue_cnt=%h sel_err=%b, expected 0/0", if4.issue_cnt, if4.sel_err);
    end
    n_tests++;
    if (if3.out_valid !== 3'b000 || if3.issue_cnt !== 24'd0 || if3.sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut3: valid=%b cnt=%h sel_err=%b, expected 0", if3.out_valid, if3.issue_cnt, if3.sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] a;
    if4.out_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      a = 16'h1111 * 16'(s + 1);
      @(negedge clk);
      beat4(2'(s), a, ~a);
      #1;
      n_tests++;
      if (if4.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_in_ready[%0d]: got %b expected 1", s, if4.in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (if4.out_valid !== (4'b0001 << s) || rs1_4(s) !== a || rs2_4(s) !== ~a) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: valid=%b rs1=%h rs2=%h expected valid=%b rs1=%h rs2=%h",
                 s, if4.out_valid, rs1_4(s), rs2_4(s), 4'b0001 << s, a, ~a);
      end
    end
    @(negedge clk);
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_one_cycle: valid=%b expected 0000", if4.out_valid);
    end
    n_tests++;
    if (if4.issue_cnt !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL basic_cnt: got %h expected 01010101", if4.issue_cnt);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    if4.out_ready = 4'b0111;
    beat4(2'd3, 16'hA3A3, 16'h3A3A);
    @(posedge clk);
    @(negedge clk);
    beat4(2'd3, 16'hBBBB, 16'hCCCC);
    #1;
    n_tests++;
    if (if4.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready_ch3: got %b expected 0", if4.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid[3] !== 1'b1 || rs1_4(3) !== 16'hA3A3 || rs2_4(3) !== 16'h3A3A || cnt_4(3) !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_ch3_stable: v=%b rs1=%h rs2=%h cnt=%0d expected 1 a3a3 3a3a 2",
               if4.out_valid[3], rs1_4(3), rs2_4(3), cnt_4(3));
    end
    @(negedge clk);
    beat4(2'd1, 16'h0C01, 16'h0C02);
    #1;
    n_tests++;
    if (if4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_in_ready_ch1: got %b expected 1", if4.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid !== 4'b1010 || rs1_4(1) !== 16'h0C01 || rs1_4(3) !== 16'hA3A3) begin
      n_fail++;
      $display("FAIL bp_no_hol: valid=%b rs1[1]=%h rs1[3]=%h expected 1010 0c01 a3a3",
               if4.out_valid, rs1_4(1), rs1_4(3));
    end
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    beat4(2'd2, 16'h2201, 16'h2211);
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid[2] !== 1'b1 || rs1_4(2) !== 16'h2201) begin
      n_fail++;
      $display("FAIL pt_first: v=%b rs1=%h expected 1 2201", if4.out_valid[2], rs1_4(2));
    end
    @(negedge clk);
    beat4(2'd2, 16'h2202, 16'h2212);
    #1;
    n_tests++;
    if (if4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pt_in_ready: got %b expected 1", if4.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid !== 4'b1100 || rs1_4(2) !== 16'h2202 || rs2_4(2) !== 16'h2212 || cnt_4(2) !== 8'd3) begin
      n_fail++;
      $display("FAIL pt_reload: valid=%b rs1=%h rs2=%h cnt=%0d expected 1100 2202 2212 3",
               if4.out_valid, rs1_4(2), rs2_4(2), cnt_4(2));
    end
    @(negedge clk);
    if4.in_valid  = 1'b0;
    if4.out_ready = 4'b0000;
    @(posedge clk);
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush4 = 1'b1;
    beat4(2'd0, 16'hDEAD, 16'hBEEF);
    #1;
    n_tests++;
    if (if4.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b expected 0", if4.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid !== 4'b0000 || cnt_4(0) !== 8'd1 || rs1_4(0) !== 16'h1111 || rs1_4(2) !== 16'h2202) begin
      n_fail++;
      $display("FAIL flush_result: valid=%b cnt0=%0d rs1[0]=%h rs1[2]=%h expected 0000 1 1111 2202",
               if4.out_valid, cnt_4(0), rs1_4(0), rs1_4(2));
    end
    @(negedge clk);
    flush4       = 1'b0;
    if4.in_valid = 1'b0;
  endtask

  task automatic test_invalid_sel();
    @(negedge clk);
    if3.out_ready = 3'b000;
    if3.in_valid  = 1'b1;
    if3.in_sel    = 2'd0;
    if3.in_rs1    = 16'h0303;
    if3.in_rs2    = 16'h3030;
    @(posedge clk);
    @(negedge clk);
    if3.in_sel = 2'd3;
    if3.in_rs1 = 16'hFFFF;
    #1;
    n_tests++;
    if (if3.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL badsel_in_ready: got %b expected 1", if3.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (if3.sel_err !== 1'b1 || if3.out_valid !== 3'b001 || if3.issue_cnt !== 24'h000001
        || if3.out_rs1[15:0] !== 16'h0303) begin
      n_fail++;
      $display("FAIL badsel_pulse: sel_err=%b valid=%b cnt=%h rs1[0]=%h expected 1 001 000001 0303",
               if3.sel_err, if3.out_valid, if3.issue_cnt, if3.out_rs1[15:0]);
    end
    @(negedge clk);
    if3.in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (if3.sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL badsel_one_cycle: sel_err=%b expected 0", if3.sel_err);
    end
  endtask

  task automatic test_back_to_back_wrap();
    // ch0 holds count 1; 254 beats take it to 255, one more wraps to 0.
    @(negedge clk);
    if4.out_ready = 4'b0001;
    for (int i = 0; i < 254; i++) begin
      beat4(2'd0, 16'(i), 16'(i + 1000));
      @(negedge clk);
    end
    n_tests++;
    if (cnt_4(0) !== 8'd255 || rs1_4(0) !== 16'd253 || if4.out_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_255: cnt=%0d rs1=%0d v=%b expected 255 253 1", cnt_4(0), rs1_4(0), if4.out_valid[0]);
    end
    beat4(2'd0, 16'h7777, 16'h8888);
    @(negedge clk);
    n_tests++;
    if (cnt_4(0) !== 8'd0 || rs1_4(0) !== 16'h7777) begin
      n_fail++;
      $display("FAIL b2b_wrap: cnt=%0d rs1=%h expected 0 7777", cnt_4(0), rs1_4(0));
    end
    n_tests++;
    if (cnt_4(1) !== 8'd2 || cnt_4(2) !== 8'd3 || cnt_4(3) !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b_others: cnt1=%0d cnt2=%0d cnt3=%0d expected 2 3 2", cnt_4(1), cnt_4(2), cnt_4(3));
    end
  endtask

  task automatic test_reset_mid_stall();
    if4.out_ready = 4'b0000;
    beat4(2'd3, 16'h5A5A, 16'hA5A5);
    @(negedge clk);
    if4.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (if4.out_valid !== 4'b0000 || if4.out_rs1 !== 64'd0 || if4.out_rs2 !== 64'd0
        || if4.issue_cnt !== 32'd0 || if4.sel_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_stall: valid=%b rs1=%h rs2=%h cnt=%h sel_err=%b expected all 0",
               if4.out_valid, if4.out_rs1, if4.out_rs2, if4.issue_cnt, if4.sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    flush4        = 1'b0;
    flush3        = 1'b0;
    if4.in_valid  = 1'b0;
    if4.in_sel    = '0;
    if4.in_rs1    = '0;
    if4.in_rs2    = '0;
    if4.out_ready = '0;
    if3.in_valid  = 1'b0;
    if3.in_sel    = '0;
    if3.in_rs1    = '0;
    if3.in_rs2    = '0;
    if3.out_ready = '0;

    test_reset();
    test_basic();
    test_backpressure();
    test_pass_through();
    test_flush();
    test_invalid_sel();
    test_back_to_back_wrap();
    test_reset_mid_stall();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
